// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, NPC adder loop, redirect and decode-side valid/ready.
// fetch_err is present only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_unit_if;
   logic [31:0] pc_out;
   logic [31:0] npc_in;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_err;
`endif

   modport master (
      output pc_out, imem_req, if_valid, if_instr, if_pc,
`ifdef FETCH_ALIGN_CHECK_EN
      output fetch_err,
`endif
      input  npc_in, imem_ack, imem_rdata, redirect, redirect_pc, if_ready
   );

   modport slave (
      input  pc_out, imem_req, if_valid, if_instr, if_pc,
`ifdef FETCH_ALIGN_CHECK_EN
      input  fetch_err,
`endif
      output npc_in, imem_ack, imem_rdata, redirect, redirect_pc, if_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// MIPS-32 instruction-fetch front end: PC register, req/ack fetch, 2-entry {pc, instr} FIFO to decode.
// Optional FETCH_ALIGN_CHECK_EN adds a HALT state and sticky fetch_err on misaligned redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DRAIN = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
      ,ST_HALT = 2'd2
`endif
   } state_t;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFC;
`endif

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_pend_pc, w_pend_nxt;
   logic        r_hold;
   logic        r_run;
   logic [1:0]  r_count, w_count_nxt;
   logic        r_head;
   logic [31:0] r_fifo_pc    [2];
   logic [31:0] r_fifo_instr [2];
   logic        w_req, w_ack, w_push, w_pop, w_flush, w_tail;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        r_err, w_err_nxt;
`endif

   // r_run keeps imem_req low throughout reset and for the release cycle.
   assign w_req  = r_run && (r_hold || (r_state == ST_FETCH && r_count != 2'd2));
   assign w_ack  = w_req && bus.imem_ack;
   assign w_pop  = (r_count != 2'd0) && bus.if_ready;
   assign w_tail = r_head ^ r_count[0];

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pend_nxt  = r_pend_pc;
      w_flush     = 1'b0;
      w_push      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      w_err_nxt   = r_err;
`endif
      case (r_state)
         ST_FETCH: begin
            if (bus.redirect) begin
               w_flush = 1'b1;
               if (w_req && !bus.imem_ack) begin
                  w_pend_nxt  = bus.redirect_pc;
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_pc_nxt = bus.redirect_pc & TGT_MASK;
`ifdef FETCH_ALIGN_CHECK_EN
                  if (bus.redirect_pc[1:0] != 2'b00) begin
                     w_state_nxt = ST_HALT;
                     w_err_nxt   = 1'b1;
                  end
`endif
               end
            end else if (w_ack) begin
               w_push   = 1'b1;
               w_pc_nxt = bus.npc_in;
            end
         end
         ST_DRAIN: begin
            // The old request must complete; only the newest redirect target survives.
            if (bus.redirect) begin
               w_flush    = 1'b1;
               w_pend_nxt = bus.redirect_pc;
            end
            if (w_ack) begin
               w_pc_nxt    = w_pend_nxt & TGT_MASK;
               w_state_nxt = ST_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
               if (w_pend_nxt[1:0] != 2'b00) begin
                  w_state_nxt = ST_HALT;
                  w_err_nxt   = 1'b1;
               end
`endif
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         ST_HALT: begin
            if (bus.redirect) begin
               w_flush  = 1'b1;
               w_pc_nxt = bus.redirect_pc;
               if (bus.redirect_pc[1:0] == 2'b00) begin
                  w_state_nxt = ST_FETCH;
                  w_err_nxt   = 1'b0;
               end
            end
         end
`endif
         default: w_state_nxt = ST_FETCH;
      endcase

      w_count_nxt = r_count;
      if (w_flush)
         w_count_nxt = 2'd0;
      else if (w_push && !w_pop)
         w_count_nxt = r_count + 2'd1;
      else if (!w_push && w_pop)
         w_count_nxt = r_count - 2'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_FETCH;
         r_pc      <= RESET_PC;
         r_pend_pc <= 32'd0;
         r_hold    <= 1'b0;
         r_run     <= 1'b0;
         r_count   <= 2'd0;
         r_head    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         r_err     <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pend_pc <= w_pend_nxt;
         r_hold    <= w_req && !bus.imem_ack;
         r_run     <= 1'b1;
         r_count   <= w_count_nxt;
         if (w_pop && !w_flush)
            r_head <= ~r_head;
`ifdef FETCH_ALIGN_CHECK_EN
         r_err     <= w_err_nxt;
`endif
      end
   end

   // NOTE: the FIFO storage is reset because if_instr/if_pc must read 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_pc[i]    <= 32'd0;
            r_fifo_instr[i] <= 32'd0;
         end
      end else if (w_push) begin
         r_fifo_pc[w_tail]    <= r_pc;
         r_fifo_instr[w_tail] <= bus.imem_rdata;
      end
   end

   assign bus.pc_out   = r_pc;
   assign bus.imem_req = w_req;
   assign bus.if_valid = (r_count != 2'd0);
   assign bus.if_instr = r_fifo_instr[r_head];
   assign bus.if_pc    = r_fifo_pc[r_head];
`ifdef FETCH_ALIGN_CHECK_EN
   assign bus.fetch_err = r_err;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a configurable-latency instruction memory model.
// Exercises streaming, backpressure, drain redirects, flush-on-pop and the misaligned-target path.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int latency = 0;
   int lat_cnt;
   int n_checks = 0;
   int n_pass = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // NPC adder and memory: ack after `latency` wait cycles of a held request.
   always_comb begin
      bus.npc_in     = bus.pc_out + 32'd4;
      bus.imem_ack   = bus.imem_req && (lat_cnt >= latency);
      bus.imem_rdata = bus.imem_ack ? mem_word(bus.pc_out) : 32'hDEAD_BEEF;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lat_cnt <= 0;
      else if (bus.imem_req && !bus.imem_ack)
         lat_cnt <= lat_cnt + 1;
      else
         lat_cnt <= 0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset(input int lat, input logic rdy);
      rst_n           = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.if_ready    = rdy;
      latency         = lat;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus.if_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, bus.if_valid}, 32'd1);
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      bus.redirect    = 1'b1;
      bus.redirect_pc = target;
   endtask

   initial begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.if_ready    = 1'b1;

      // Reset values
      @(negedge clk);
      check("rst_pc",    bus.pc_out,   32'h0000_3000);
      check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
      check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_instr", bus.if_instr, 32'd0);
      check("rst_ifpc",  bus.if_pc,    32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("rst_err",   {31'd0, bus.fetch_err}, 32'd0);
`endif

      // Zero-wait streaming, one instruction per cycle
      do_reset(0, 1'b1);
      @(negedge clk);
      check("s_req1",   {31'd0, bus.imem_req}, 32'd1);
      check("s_pc1",    bus.pc_out, 32'h0000_3000);
      check("s_valid1", {31'd0, bus.if_valid}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("s_valid", {31'd0, bus.if_valid}, 32'd1);
         check("s_ifpc",  bus.if_pc, 32'h0000_3000 + 32'(4 * k));
         check("s_instr", bus.if_instr, mem_word(32'h0000_3000 + 32'(4 * k)));
      end

      // Backpressure: FIFO fills, request drops, then in-order delivery
      do_reset(0, 1'b0);
      repeat (5) @(negedge clk);
      check("bp_req",   {31'd0, bus.imem_req}, 32'd0);
      check("bp_valid", {31'd0, bus.if_valid}, 32'd1);
      check("bp_ifpc0", bus.if_pc, 32'h0000_3000);
      bus.if_ready = 1'b1;
      @(negedge clk);
      check("bp_ifpc1", bus.if_pc, 32'h0000_3004);
      check("bp_req1",  {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk);
      check("bp_ifpc2", bus.if_pc, 32'h0000_3008);

      // 3-wait memory, redirect in 2nd wait cycle
      do_reset(3, 1'b1);
      @(negedge clk);
      check("d_ack0", {31'd0, bus.imem_ack}, 32'd0);
      @(negedge clk);
      pulse_redirect(32'h0000_4000);
      @(negedge clk);
      bus.redirect = 1'b0;
      check("d_pc_hold", bus.pc_out, 32'h0000_3000);
      check("d_req_hold", {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk);
      check("d_ack", {31'd0, bus.imem_ack}, 32'd1);
      check("d_pc_ack", bus.pc_out, 32'h0000_3000);
      @(negedge clk);
      check("d_pc_new", bus.pc_out, 32'h0000_4000);
      check("d_valid",  {31'd0, bus.if_valid}, 32'd0);
      wait_valid("d_wait");
      check("d_ifpc", bus.if_pc, 32'h0000_4000);
      check("d_instr", bus.if_instr, mem_word(32'h0000_4000));

      // Two redirects in one drain: newest wins
      do_reset(3, 1'b1);
      @(negedge clk);
      pulse_redirect(32'h0000_5000);
      @(negedge clk);
      pulse_redirect(32'h0000_6000);
      @(negedge clk);
      bus.redirect = 1'b0;
      check("dd_pc_hold", bus.pc_out, 32'h0000_3000);
      @(negedge clk);
      check("dd_ack", {31'd0, bus.imem_ack}, 32'd1);
      @(negedge clk);
      check("dd_pc_new", bus.pc_out, 32'h0000_6000);
      wait_valid("dd_wait");
      check("dd_ifpc", bus.if_pc, 32'h0000_6000);

      // Redirect coinciding with ack and pop
      do_reset(0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("fp_ifpc", bus.if_pc, 32'h0000_3000);
      pulse_redirect(32'h0000_7000);
      @(negedge clk);
      bus.redirect = 1'b0;
      check("fp_valid", {31'd0, bus.if_valid}, 32'd0);
      check("fp_pc",    bus.pc_out, 32'h0000_7000);
      check("fp_req",   {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk);
      check("fp_ifpc2", bus.if_pc, 32'h0000_7000);

      // Misaligned redirect
      pulse_redirect(32'h0000_8002);
      @(negedge clk);
      bus.redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      check("ma_err",   {31'd0, bus.fetch_err}, 32'd1);
      check("ma_req",   {31'd0, bus.imem_req}, 32'd0);
      repeat (3) @(negedge clk);
      check("ma_req3",  {31'd0, bus.imem_req}, 32'd0);
      check("ma_valid", {31'd0, bus.if_valid}, 32'd0);
      check("ma_err3",  {31'd0, bus.fetch_err}, 32'd1);
      pulse_redirect(32'h0000_9000);
      @(negedge clk);
      bus.redirect = 1'b0;
      check("ma_err_clr", {31'd0, bus.fetch_err}, 32'd0);
      check("ma_pc",      bus.pc_out, 32'h0000_9000);
      check("ma_req_on",  {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk);
      check("ma_ifpc", bus.if_pc, 32'h0000_9000);
`else
      check("ma_pc",    bus.pc_out, 32'h0000_8000);
      check("ma_valid", {31'd0, bus.if_valid}, 32'd0);
      @(negedge clk);
      check("ma_ifpc", bus.if_pc, 32'h0000_8000);
`endif

      // Address wrap-around through the NPC adder
      pulse_redirect(32'hFFFF_FFFC);
      @(negedge clk);
      bus.redirect = 1'b0;
      check("w_pc", bus.pc_out, 32'hFFFF_FFFC);
      @(negedge clk);
      check("w_ifpc0", bus.if_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      check("w_ifpc1", bus.if_pc, 32'h0000_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the single-clock MIPS-32 core. Holds the architectural PC, issues word fetches to instruction memory over a req/ack handshake, and buffers fetched instructions in a 2-entry FIFO toward decode with valid/ready. It consumes the PC+4 value produced by the NPC adder from its own `pc_out`, and takes branch/jump redirects from the execute stage.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `npc_in` in 32: sequential next PC (`pc_out`+4) from the NPC adder.
- `pc_out` out 32: current fetch address; drives the NPC adder and imem address.
- `imem_req` out 1: fetch request at address `pc_out`.
- `imem_ack` in 1: memory accepts the request and returns `imem_rdata` in the same cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_ack`=1.
- `redirect` in 1: one-cycle pulse; flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: branch/jump target.
- `if_valid` out 1: FIFO head holds an instruction.
- `if_ready` in 1: decode consumes the head this cycle when `if_valid`=1.
- `if_instr` out 32: head instruction.
- `if_pc` out 32: address of the head instruction.
- `fetch_err` out 1: sticky misaligned-redirect flag; exists only with the macro defined, see Configuration.

## Operation
- States: FETCH, DRAIN, and HALT (HALT only with the macro defined).
- FIFO: 2 entries of {pc, instr}, with a registered `count` of 0..2.
- `if_valid` = (`count`!=0). `if_instr` and `if_pc` come from the head entry.
- Push on accepted ack, pop on `if_valid`&&`if_ready`. Push and pop in the same cycle leave `count` unchanged.
- `hold` register: set when `imem_req`=1 and `imem_ack`=0; cleared on ack.
- `imem_req` = `hold` || (state==FETCH && `count`<2).
- Once asserted, `imem_req` and `pc_out` stay stable until ack, whatever `if_ready`, `redirect` or the FIFO does.
- A single outstanding request always has a FIFO slot, because `count` only rises on ack.
- FETCH, ack with no redirect: push {`pc_out`, `imem_rdata`}; `pc_out` <= `npc_in`.
- FETCH, redirect with no outstanding request (`imem_req`=0, or `imem_req`=1 and `imem_ack`=1): flush FIFO (`count`<=0). Any ack data that cycle is discarded. `pc_out` <= `redirect_pc`. Stay in FETCH.
- FETCH, redirect while `imem_req`=1 and `imem_ack`=0:
  - flush FIFO and latch `pend_pc` <= `redirect_pc`;
  - go to DRAIN; `pc_out` keeps the old address.
- DRAIN:
  - keep requesting the old address and discard its data;
  - a further redirect overwrites `pend_pc`, with the newest value winning;
  - on ack, `pc_out` <= `pend_pc` and return to FETCH;
  - the FIFO takes no pushes in DRAIN.
- Redirect and pop in the same cycle: the flush wins and `count`=0.
- Address arithmetic is 32-bit; wrap-around past 32'hFFFF_FFFC comes from `npc_in` and needs no special case.

## Timing
- Reset values: `pc_out`=`RESET_PC`, `imem_req`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `fetch_err`=0, state=FETCH, `count`=0, `hold`=0.
- Reset mid-operation aborts any outstanding request immediately.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- Zero-wait memory (ack in the request cycle):
  - `if_valid` rises one cycle after the ack;
  - sustained throughput is 1 instruction/cycle with `if_ready`=1.
- `pc_out` updates on the clock edge that ends the ack cycle.
- Redirect latency:
  - no request outstanding: the first request to the target goes out in the next cycle;
  - request outstanding: the first request to the target goes out in the cycle after the draining ack.
- No combinational path from `imem_ack` or `if_ready` to `imem_req` within a cycle; `imem_req` depends only on registers.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined:
  - a redirect with `redirect_pc[1:0]`!=0 loads the target but then enters HALT, immediately or after DRAIN completes;
  - in HALT, `fetch_err`=1 (sticky), `imem_req`=0 and the FIFO stays empty;
  - only an aligned redirect clears `fetch_err` and resumes in FETCH.
- Undefined:
  - no HALT state and no `fetch_err` port;
  - redirect targets load as {`redirect_pc[31:2]`, 2'b00}.

## Test plan
- Reset release, `imem_ack` tied to `imem_req`, `if_ready`=1 → `if_pc` sequence 0x3000, 0x3004, 0x3008… with one new value every cycle, starting 2 cycles after release.
- `if_ready`=0 for 5 cycles → `count` saturates at 2 and `imem_req` drops. Release → 0x3000 and 0x3004 are delivered in order with no loss or duplicate.
- 3-cycle-latency memory, redirect to 0x4000 in the 2nd wait cycle → `pc_out` holds its old value until the ack, that data is discarded, the next request address is 0x4000, and the first `if_pc` after the redirect is 0x4000.
- Two redirects (0x5000, then 0x6000) during one drain → fetch resumes at 0x6000 only.
- Redirect to 0x7000 in the same cycle as an ack and a pop → FIFO empty the next cycle, and the next request address is 0x7000.
- Macro defined, redirect to 0x8002 → `fetch_err`=1 and no requests. Then redirect to 0x9000 → `fetch_err`=0 and fetch resumes at 0x9000. Macro undefined, redirect to 0x8002 → fetch at 0x8000.
